// File: rtl/sram_bus_ctrl.sv
// AVR-side SRAM access sequencer with serial address load, SNES bus pass-through and wait-state strobing.
// Optional build macro SRAM_AUTO_INC_EN: bump the address by one on every completed access.
module sram_bus_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 21,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              avr_sreg_en_n,
    input  logic              avr_si,
    input  logic              avr_oe_n,
    input  logic              avr_we_n,
    input  logic              avr_counter_n,
    input  logic [DATA_W-1:0] avr_data_in,
    output logic [DATA_W-1:0] avr_data_out,
    input  logic              avr_snes_mode,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic              snes_rd_n,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

`ifdef SRAM_AUTO_INC_EN
    localparam logic [1:0] AUTO_INC = 2'd1;
`else
    localparam logic [1:0] AUTO_INC = 2'd0;
`endif

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pend_q, pend_d;
    logic [2:0]          smp_q, prv_q;
    logic [2:0]          ev;
    logic                rd_ev, wr_ev, inc_ev;
    logic [1:0]          inc_amt;
    logic                ce_n_q, oe_n_q, we_n_q, doe_q, done_q;
    logic                ce_n_d, oe_n_d, we_n_d, doe_d, done_d;

    // Bit order: {counter, we, oe}; an event is a 1 -> 0 step between two registered samples.
    assign ev     = prv_q & ~smp_q;
    assign rd_ev  = ev[0];
    assign wr_ev  = ev[1];
    assign inc_ev = ev[2];

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            smp_q <= 3'b111;
            prv_q <= 3'b111;
        end else begin
            smp_q <= {avr_counter_n, avr_we_n, avr_oe_n};
            prv_q <= smp_q;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (avr_sreg_en_n) begin
                    if (rd_ev) begin
                        state_d = ST_RD;
                        wait_d  = WAIT_LOAD;
                    end else if (wr_ev) begin
                        state_d = ST_WR;
                        wait_d  = WAIT_LOAD;
                        wdata_d = avr_data_in;
                    end
                end
            end
            ST_RD: begin
                if (wait_q == 4'd0) begin
                    rdata_d = sram_data_in;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WR: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WR_HOLD: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // SNES ownership aborts any access in flight and discards its side effects.
        if (avr_snes_mode) begin
            state_d = ST_IDLE;
            rdata_d = rdata_q;
            wdata_d = wdata_q;
        end
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_comb begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        doe_d  = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            ST_WR: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                doe_d  = 1'b1;
            end
            ST_WR_HOLD: begin
                ce_n_d = 1'b0;
                doe_d  = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        pend_d  = pend_q;
        inc_amt = 2'd0;
        if (state_q == ST_DONE) begin
            pend_d = 1'b0;
        end
        if (!avr_sreg_en_n) begin
            addr_d = {addr_q[ADDR_W-2:0], avr_si};
        end else if (avr_snes_mode) begin
            pend_d = 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                inc_amt = {1'b0, inc_ev};
            end else if (state_q == ST_DONE) begin
                // An increment landing in the DONE cycle itself is folded into the pending one.
                inc_amt = {1'b0, pend_q | inc_ev} + AUTO_INC;
            end else if (inc_ev) begin
                pend_d = 1'b1;
            end
            addr_d = addr_q + ADDR_W'(inc_amt);
        end
    end

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
            done_q  <= done_d;
        end
    end

    // SNES pass-through is combinational so the console sees no extra cycle of delay.
    assign sram_addr     = avr_snes_mode ? snes_addr : addr_q;
    assign sram_oe_n     = avr_snes_mode ? snes_rd_n : oe_n_q;
    assign sram_ce_n     = avr_snes_mode ? 1'b0      : ce_n_q;
    assign sram_we_n     = avr_snes_mode ? 1'b1      : we_n_q;
    assign sram_data_oe  = avr_snes_mode ? 1'b0      : doe_q;
    assign sram_data_out = wdata_q;
    assign avr_data_out  = rdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule
